// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types and defaults for the sum job scheduler
package sched_pkg;

    localparam int TAG_W       = 8;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DEPTH   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sum_job_scheduler_if.sv
// rtl/sum_job_scheduler_if.sv - job intake and result handshake bundle
interface sum_job_scheduler_if
    import sched_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              job_valid;
    logic              job_ready;
    logic [ADDR_W-1:0] job_head;
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_sum;
    logic [TAG_W-1:0]  res_tag;
    logic              res_err;

    // Host / job source side
    modport master (
        output job_valid, job_head, res_ready,
        input  job_ready, res_valid, res_sum, res_tag, res_err
    );

    // Scheduler side
    modport slave (
        input  job_valid, job_head, res_ready,
        output job_ready, res_valid, res_sum, res_tag, res_err
    );
endinterface

// File: rtl/sched_fifo.sv
// rtl/sched_fifo.sv - DEPTH x W job FIFO with full/empty flags
module sched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    // Extra pointer bit distinguishes full from empty when indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; refused pushes/pops leave pointers unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; empty flag guards reads
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sum_job_scheduler.sv
// rtl/sum_job_scheduler.sv - sequences list-sum jobs through the engine; SCHED_TIMEOUT_EN adds a watchdog
module sum_job_scheduler
    import sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    sum_job_scheduler_if.slave   bus,
    output logic                 eng_start,
    output logic [ADDR_W-1:0]    eng_head,
    input  logic                 eng_done,
    input  logic [WIDTH-1:0]     eng_sum,
    output logic                 busy
);
    // Elaboration-time sanity check on the watchdog limit
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    sched_state_t      state_q, state_d;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_dout;
    logic              done_q;
    logic              done_rise;
    logic              wd_expire;
    logic [WIDTH-1:0]  res_sum_q;
    logic [TAG_W-1:0]  res_tag_q;

    sched_fifo #(.DEPTH(DEPTH), .W(ADDR_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.job_valid && bus.job_ready),
        .din   (bus.job_head),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.job_ready = !fifo_full;
    assign bus.res_valid = (state_q == S_HOLD);
    assign bus.res_sum   = res_sum_q;
    assign bus.res_tag   = res_tag_q;
    assign busy          = (state_q != S_IDLE) || !fifo_empty;
    assign done_rise     = eng_done && !done_q;

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             res_err_q;

    assign wd_expire   = (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign bus.res_err = res_err_q;

    // Watchdog: cleared at START, counts each WAIT cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if (state_q == S_START)
            wd_cnt <= '0;
        else if (state_q == S_WAIT)
            wd_cnt <= wd_cnt + 1'b1;
    end

    // Error flag: a done edge wins over a coincident watchdog expiry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            res_err_q <= 1'b0;
        else if (state_q == S_WAIT && done_rise)
            res_err_q <= 1'b0;
        else if (state_q == S_WAIT && wd_expire)
            res_err_q <= 1'b1;
    end
`else
    assign wd_expire   = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state and per-state strobes
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        eng_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                eng_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise || wd_expire)
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Done edge detector; a level left high from a prior job never counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            done_q <= 1'b0;
        else
            done_q <= eng_done;
    end

    // Head address held for the engine from pop until the next pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            eng_head <= '0;
        else if (fifo_pop)
            eng_head <= fifo_dout;
    end

    // Result capture: engine sum on done edge, zero on watchdog abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            res_sum_q <= '0;
        else if (state_q == S_WAIT && done_rise)
            res_sum_q <= eng_sum;
        else if (state_q == S_WAIT && wd_expire)
            res_sum_q <= '0;
    end

    // Job tag advances once per consumed result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            res_tag_q <= '0;
        else if (state_q == S_HOLD && bus.res_ready)
            res_tag_q <= res_tag_q + 1'b1;
    end
endmodule

// File: tb/tb_sum_job_scheduler.sv
// tb/tb_sum_job_scheduler.sv - self-checking bench for sum_job_scheduler
module tb_sum_job_scheduler;
    import sched_pkg::*;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
`ifdef SCHED_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 255;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              eng_start;
    logic [ADDR_W-1:0] eng_head;
    logic              eng_done;
    logic [WIDTH-1:0]  eng_sum;
    logic              busy;

    always #5 clk = ~clk;

    sum_job_scheduler_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    sum_job_scheduler #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .eng_start (eng_start),
        .eng_head  (eng_head),
        .eng_done  (eng_done),
        .eng_sum   (eng_sum),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] sum;
        logic [7:0] tag;
        logic       err;
    } res_t;

    typedef struct {
        logic [7:0] head;
        int         lat;
        logic [7:0] exp_sum;
    } vec_t;

    res_t       exp_q [$];
    logic [7:0] head_q [$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] exp_tag = 8'd0;
    int         n_results = 0;
    int         res_cyc = 0;
    int         res_start = 0;
    int         last_start_cyc = 0;

    int         eng_lat = 5;
    bit         eng_stall = 1'b0;
    bit         eng_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Engine model: sum = head + 0x1A, done after eng_lat cycles from start
    initial begin
        bit         e_busy;
        int         e_cnt;
        logic [7:0] e_head;
        e_busy   = 1'b0;
        e_cnt    = 0;
        e_head   = 8'd0;
        eng_done = 1'b0;
        eng_sum  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                e_busy   = 1'b0;
                eng_done = 1'b0;
            end else if (eng_start) begin
                last_start_cyc = cyc;
                if (head_q.size() == 0) begin
                    check("unexpected eng_start", 32'd1, 32'd0);
                end else begin
                    check("eng_head", {24'd0, eng_head}, {24'd0, head_q.pop_front()});
                end
                e_busy = 1'b1;
                e_cnt  = eng_lat;
                e_head = eng_head;
                if (!eng_hold)
                    eng_done = 1'b0;
            end else if (e_busy && !eng_stall) begin
                e_cnt--;
                if (e_cnt <= 0) begin
                    eng_done = 1'b1;
                    eng_sum  = e_head + 8'h1A;
                    e_busy   = 1'b0;
                end else if (e_cnt == 1) begin
                    eng_done = 1'b0;
                end
            end else if (!eng_hold) begin
                eng_done = 1'b0;
            end
        end
    end

    // Scoreboard: compare each consumed result against the queue head
    initial forever begin
        @(negedge clk);
        if (rst && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("res_sum", {24'd0, bus.res_sum}, {24'd0, e.sum});
                check("res_tag", {24'd0, bus.res_tag}, {24'd0, e.tag});
                check("res_err", {31'd0, bus.res_err}, {31'd0, e.err});
            end
            n_results++;
            res_cyc   = cyc;
            res_start = last_start_cyc;
        end
    end

    task automatic offer(input logic [7:0] head, input logic [7:0] sum, input logic err,
                         output bit acc, output int acc_cyc);
        res_t e;
        @(posedge clk);
        #1;
        bus.job_valid = 1'b1;
        bus.job_head  = head;
        acc_cyc       = cyc;
        @(negedge clk);
        acc = bus.job_ready;
        if (acc) begin
            e.sum = sum;
            e.tag = exp_tag;
            e.err = err;
            exp_q.push_back(e);
            head_q.push_back(head);
            exp_tag++;
        end
    endtask

    task automatic job_idle();
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_results(input int target, input int max_cyc);
        int n;
        n = 0;
        while (n_results < target && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("result wait", {31'd0, n_results >= target}, 32'd1);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", {31'd0, exp_q.size() == 0 && !busy}, 32'd1);
    endtask

    vec_t vecs [5];
    bit   acc;
    int   acc_cyc;
    int   n_acc;
    int   t_start;
    logic [7:0] hold_sum;
    logic [7:0] hold_tag;

    initial begin
        vecs[0] = '{head: 8'h10, lat: 5, exp_sum: 8'h2A};
        vecs[1] = '{head: 8'h00, lat: 1, exp_sum: 8'h1A};
        vecs[2] = '{head: 8'hFF, lat: 3, exp_sum: 8'h19};
        vecs[3] = '{head: 8'h55, lat: 2, exp_sum: 8'h6F};
        vecs[4] = '{head: 8'hE6, lat: 4, exp_sum: 8'h00};

        bus.job_valid = 1'b0;
        bus.job_head  = '0;
        bus.res_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset job_ready", {31'd0, bus.job_ready}, 32'd1);
        check("reset res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("reset eng_start", {31'd0, eng_start}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset res_tag", {24'd0, bus.res_tag}, 32'd0);
        check("reset res_sum", {24'd0, bus.res_sum}, 32'd0);
        check("reset res_err", {31'd0, bus.res_err}, 32'd0);
        check("reset eng_head", {24'd0, eng_head}, 32'd0);
        rst = 1'b1;

        // Table of single jobs: start latency, result latency, sum and tag
        for (int i = 0; i < 5; i++) begin
            eng_lat = vecs[i].lat;
            offer(vecs[i].head, vecs[i].exp_sum, 1'b0, acc, acc_cyc);
            check("single accept", {31'd0, acc}, 32'd1);
            job_idle();
            wait_results(n_results + 1, 60);
            check("start latency", res_start, acc_cyc + 2);
            check("result latency", res_cyc, res_start + vecs[i].lat + 1);
            drain(20);
        end

        // Stalled engine: 1 in flight + DEPTH queued, then backpressure
        eng_stall = 1'b1;
        eng_lat   = 2;
        n_acc     = 0;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] h;
            h = 8'h20 + 8'(i);
            offer(h, h + 8'h1A, 1'b0, acc, acc_cyc);
            if (acc) n_acc++;
        end
        job_idle();
        @(negedge clk);
        check("accepted while stalled", n_acc, 5);
        check("job_ready when full", {31'd0, bus.job_ready}, 32'd0);
        eng_stall = 1'b0;
        drain(200);

        // Result held with res_ready low: stable outputs, no new start
        bus.res_ready = 1'b0;
        eng_lat = 2;
        offer(8'h30, 8'h4A, 1'b0, acc, acc_cyc);
        offer(8'h31, 8'h4B, 1'b0, acc, acc_cyc);
        job_idle();
        begin
            int n;
            n = 0;
            while (!bus.res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        hold_sum = exp_q[0].sum;
        hold_tag = exp_q[0].tag;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold res_valid", {31'd0, bus.res_valid}, 32'd1);
            check("hold res_sum", {24'd0, bus.res_sum}, {24'd0, hold_sum});
            check("hold res_tag", {24'd0, bus.res_tag}, {24'd0, hold_tag});
            check("hold eng_start", {31'd0, eng_start}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        drain(100);

        // Done level left high across the next start must be ignored
        eng_hold = 1'b1;
        eng_lat  = 5;
        offer(8'h40, 8'h5A, 1'b0, acc, acc_cyc);
        offer(8'h41, 8'h5B, 1'b0, acc, acc_cyc);
        job_idle();
        drain(100);
        check("held done ignored", res_cyc, res_start + 6);
        eng_hold = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-job drops everything
        eng_stall = 1'b1;
        offer(8'h50, 8'h6A, 1'b0, acc, acc_cyc);
        offer(8'h51, 8'h6B, 1'b0, acc, acc_cyc);
        offer(8'h52, 8'h6C, 1'b0, acc, acc_cyc);
        job_idle();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrun eng_start", {31'd0, eng_start}, 32'd0);
        check("midrun res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("midrun job_ready", {31'd0, bus.job_ready}, 32'd1);
        check("midrun busy", {31'd0, busy}, 32'd0);
        check("midrun res_tag", {24'd0, bus.res_tag}, 32'd0);
        exp_q.delete();
        head_q.delete();
        exp_tag   = 8'd0;
        eng_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        eng_lat = 3;
        offer(8'h60, 8'h7A, 1'b0, acc, acc_cyc);
        job_idle();
        drain(50);

`ifdef SCHED_TIMEOUT_EN
        // Watchdog abort, then the next queued job runs normally
        eng_stall = 1'b1;
        eng_lat   = 2;
        offer(8'h70, 8'h00, 1'b1, acc, acc_cyc);
        offer(8'h71, 8'h8B, 1'b0, acc, acc_cyc);
        job_idle();
        wait_results(n_results + 1, 60);
        check("timeout latency", res_cyc, res_start + 17);
        eng_stall = 1'b0;
        drain(60);
`endif

        check("scoreboard empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
